fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch front end for the 16-bit single-issue CPU: owns the PC, issues requests to instruction memory, and presents one instruction at a time to decode.
- Drives `op` into the CPU controller and consumes the controller's redirect outputs (`pcsrc`, `jump`), closing the op/redirect loop between fetch and control.
- One fetch outstanding at a time (no prefetch), so a redirect never has to kill an in-flight fetch.

Parameters:
n, 16, instruction and address width
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, byte increment per sequential instruction

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  n  fetch address
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  n  instruction word
instr  output  n  instruction presented to decode
op  output  5  instr[n-1:n-5], to controller
instr_valid  output  1  instr/op/pc are valid
instr_ready  input  1  decode accepts the instruction this cycle
pc  output  n  address of presented instruction
pcsrc  input  1  taken branch (from controller), sampled on accept
jump  input  1  jump (from controller), sampled on accept
branch_target  input  n  branch destination
jump_target  input  n  jump destination
retired  output  n  count of accepted instructions

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`reset_n`).
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr=0, pc=0, instr_valid=0, retired=0.
- FSM states:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc. Both are held stable until imem_gnt=1. On gnt, go to WAIT; imem_req drops the next cycle.
  - WAIT: on imem_rvalid=1:
    - instr<=imem_rdata, pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+PC_INC.
    - Go to HOLD.
  - HOLD: instr, op, pc and instr_valid are held stable until instr_ready=1. On accept (instr_valid & instr_ready):
    - instr_valid<=0, retired<=retired+1.
    - Next fetch_pc = jump ? jump_target : pcsrc ? branch_target : fetch_pc (already incremented).
    - Go to REQ.
- Redirect rules:
  - jump has priority over pcsrc when both are 1.
  - Redirect targets are forced to PC_INC alignment: bit 0 cleared when PC_INC=2.
  - pcsrc and jump are ignored in every cycle other than an accept.
- Timing:
  - Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle, ready held 1) gives one instruction every 3 cycles.
  - instr_valid rises the cycle after rvalid.
- Boundaries:
  - fetch_pc and retired wrap modulo 2^n; 0xFFFE + 2 = 0x0000.
  - imem_rvalid outside WAIT (IDLE, REQ, HOLD) is ignored.
  - gnt and rvalid asserted in the same cycle while in REQ: take the gnt only; that rvalid is ignored.
  - Reset mid-operation (any state) returns to the reset values immediately. A stale rvalid that arrives after reset release, before the new WAIT state, is discarded.
- op is purely combinational from the instr register; no extra latency.

Test Plan:
- Reset: reset_n=0 mid-stream -> instr_valid=0, imem_req=0, retired=0, imem_addr=0x0000. After release: IDLE for 1 cycle, then imem_req=1 with addr 0x0000.
- Sequential fetch, zero-wait memory, instr_ready=1, no redirects -> addrs 0x0000, 0x0002, 0x0004. instr_valid pulses every 3 cycles. op equals rdata[15:11]. retired=3 after the third accept.
- Stall and hold:
  - imem_gnt held low 4 cycles -> imem_req/imem_addr stable throughout.
  - instr_ready held low 5 cycles in HOLD -> instr/pc/op unchanged and retired unchanged.
- Branch: pcsrc=1 with branch_target=0x0040, accepted on the instr at pc=0x0006 -> next imem_addr=0x0040. pcsrc=1 without accept -> next addr stays 0x0008.
- Priority and alignment: jump=1, jump_target=0x0101, pcsrc=1, branch_target=0x0080 on accept -> next imem_addr=0x0100.
- Reset in WAIT, then wrap: reset_n pulsed during WAIT, followed by an rvalid in IDLE -> instr_valid stays 0. Separately, fetch at 0xFFFE -> next fetch at 0x0000.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: fetch front-end bundle between memory, decode/control and the sequencer
interface fetch_if #(parameter int n = 16);
  logic         imem_req;
  logic [n-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [n-1:0] imem_rdata;
  logic [n-1:0] instr;
  logic [4:0]   op;
  logic         instr_valid;
  logic         instr_ready;
  logic [n-1:0] pc;
  logic         pcsrc;
  logic         jump;
  logic [n-1:0] branch_target;
  logic [n-1:0] jump_target;
  logic [n-1:0] retired;
  modport master (
    output imem_req, imem_addr, instr, op, instr_valid, pc, retired,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, pcsrc, jump, branch_target, jump_target
  );
  modport slave (
    input  imem_req, imem_addr, instr, op, instr_valid, pc, retired,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, pcsrc, jump, branch_target, jump_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch with PC ownership and redirect handling
module fetch_sequencer #(
  parameter int           n        = 16,
  parameter logic [n-1:0] RESET_PC = '0,
  parameter int           PC_INC   = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [n-1:0] ALIGN = PC_INC == 2 ? {{(n-1){1'b1}}, 1'b0} : '1;
  state_t       state_q, state_d;
  logic [n-1:0] fetch_pc_q, fetch_pc_d, instr_q, instr_d, pc_q, pc_d, retired_q, retired_d;
  logic         valid_q, valid_d;
  logic         load, accept;
  logic [n-1:0] redirect_pc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      retired_q  <= retired_d;
    end
  end
  // rvalid only counts in WAIT; redirect inputs only matter on an accept in HOLD
  always_comb begin
    load        = state_q == WAIT && bus.imem_rvalid;
    accept      = state_q == HOLD && valid_q && bus.instr_ready;
    redirect_pc = bus.jump ? bus.jump_target & ALIGN : bus.pcsrc ? bus.branch_target & ALIGN : fetch_pc_q;
    fetch_pc_d  = load ? fetch_pc_q + n'(PC_INC) : accept ? redirect_pc : fetch_pc_q;
    instr_d     = load ? bus.imem_rdata : instr_q;
    pc_d        = load ? fetch_pc_q : pc_q;
    valid_d     = load || (valid_q && !accept);
    retired_d   = retired_q + n'(accept);
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = bus.imem_gnt ? WAIT : REQ;
      WAIT:    state_d = bus.imem_rvalid ? HOLD : WAIT;
      default: state_d = accept ? REQ : HOLD;
    endcase
  end
  always_comb begin
    bus.imem_req    = state_q == REQ;
    bus.imem_addr   = fetch_pc_q;
    bus.instr       = instr_q;
    bus.op          = instr_q[n-1:n-5];
    bus.instr_valid = valid_q;
    bus.pc          = pc_q;
    bus.retired     = retired_q;
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  fetch_if #(.n(16)) fi ();
  fetch_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(fi.master));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic fetch(input logic [15:0] a, input logic [15:0] d);
    chk("req_up", 32'(fi.imem_req), 1);
    chk("req_addr", 32'(fi.imem_addr), 32'(a));
    fi.imem_gnt = 1'b1;
    step();
    fi.imem_gnt = 1'b0;
    chk("req_drop", 32'(fi.imem_req), 0);
    chk("wait_valid", 32'(fi.instr_valid), 0);
    fi.imem_rvalid = 1'b1;
    fi.imem_rdata = d;
    step();
    fi.imem_rvalid = 1'b0;
    chk("hold_valid", 32'(fi.instr_valid), 1);
    chk("hold_instr", 32'(fi.instr), 32'(d));
    chk("hold_op", 32'(fi.op), 32'(d[15:11]));
    chk("hold_pc", 32'(fi.pc), 32'(a));
  endtask
  task automatic accept(input logic p, input logic j, input logic [15:0] bt, input logic [15:0] jt,
                        input logic [15:0] ret, input logic [15:0] next);
    fi.instr_ready = 1'b1;
    fi.pcsrc = p;
    fi.jump = j;
    fi.branch_target = bt;
    fi.jump_target = jt;
    step();
    fi.instr_ready = 1'b0;
    fi.pcsrc = 1'b0;
    fi.jump = 1'b0;
    chk("acc_valid", 32'(fi.instr_valid), 0);
    chk("acc_retired", 32'(fi.retired), 32'(ret));
    chk("acc_req", 32'(fi.imem_req), 1);
    chk("acc_next_addr", 32'(fi.imem_addr), 32'(next));
  endtask
  initial begin
    fi.imem_gnt = 1'b0;
    fi.imem_rvalid = 1'b0;
    fi.imem_rdata = '0;
    fi.instr_ready = 1'b0;
    fi.pcsrc = 1'b0;
    fi.jump = 1'b0;
    fi.branch_target = '0;
    fi.jump_target = '0;
    step();
    step();
    chk("rst_valid", 32'(fi.instr_valid), 0);
    chk("rst_req", 32'(fi.imem_req), 0);
    chk("rst_retired", 32'(fi.retired), 0);
    chk("rst_addr", 32'(fi.imem_addr), 0);
    chk("rst_instr", 32'(fi.instr), 0);
    chk("rst_pc", 32'(fi.pc), 0);
    reset_n = 1'b1;
    chk("idle_req", 32'(fi.imem_req), 0);
    step();
    fetch(16'h0000, 16'h8123);
    accept(0, 0, 16'h0, 16'h0, 16'd1, 16'h0002);
    fetch(16'h0002, 16'hF800);
    accept(0, 0, 16'h0, 16'h0, 16'd2, 16'h0004);
    fetch(16'h0004, 16'h0801);
    accept(0, 0, 16'h0, 16'h0, 16'd3, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req", 32'(fi.imem_req), 1);
      chk("stall_addr", 32'(fi.imem_addr), 32'h0006);
    end
    fetch(16'h0006, 16'h5A5A);
    fi.pcsrc = 1'b1;
    fi.jump = 1'b1;
    fi.branch_target = 16'h0020;
    fi.jump_target = 16'h0030;
    fi.imem_rvalid = 1'b1;
    fi.imem_rdata = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_instr_stable", 32'(fi.instr), 32'h5A5A);
      chk("hold_pc_stable", 32'(fi.pc), 32'h0006);
      chk("hold_op_stable", 32'(fi.op), 32'h0B);
      chk("hold_valid_stable", 32'(fi.instr_valid), 1);
      chk("hold_retired_stable", 32'(fi.retired), 3);
    end
    fi.imem_rvalid = 1'b0;
    accept(1, 0, 16'h0040, 16'h0, 16'd4, 16'h0040);
    fetch(16'h0040, 16'h1111);
    fi.pcsrc = 1'b1;
    fi.branch_target = 16'h0080;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("noacc_valid", 32'(fi.instr_valid), 1);
      chk("noacc_retired", 32'(fi.retired), 4);
    end
    fi.pcsrc = 1'b0;
    accept(0, 0, 16'h0080, 16'h0, 16'd5, 16'h0042);
    fetch(16'h0042, 16'h2222);
    accept(1, 1, 16'h0080, 16'h0101, 16'd6, 16'h0100);
    fi.imem_gnt = 1'b1;
    fi.imem_rvalid = 1'b1;
    fi.imem_rdata = 16'hDEAD;
    step();
    fi.imem_gnt = 1'b0;
    fi.imem_rvalid = 1'b0;
    chk("gnt_rv_valid", 32'(fi.instr_valid), 0);
    chk("gnt_rv_req", 32'(fi.imem_req), 0);
    step();
    chk("wait_idle_valid", 32'(fi.instr_valid), 0);
    fi.imem_rvalid = 1'b1;
    fi.imem_rdata = 16'h1234;
    step();
    fi.imem_rvalid = 1'b0;
    chk("gnt_rv_instr", 32'(fi.instr), 32'h1234);
    chk("gnt_rv_pc", 32'(fi.pc), 32'h0100);
    accept(0, 0, 16'h0, 16'h0, 16'd7, 16'h0102);
    fi.imem_gnt = 1'b1;
    step();
    fi.imem_gnt = 1'b0;
    chk("pre_rst_req", 32'(fi.imem_req), 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(fi.instr_valid), 0);
    chk("mid_rst_req", 32'(fi.imem_req), 0);
    chk("mid_rst_retired", 32'(fi.retired), 0);
    chk("mid_rst_addr", 32'(fi.imem_addr), 0);
    step();
    reset_n = 1'b1;
    fi.imem_rvalid = 1'b1;
    fi.imem_rdata = 16'hBEEF;
    chk("rel_idle_req", 32'(fi.imem_req), 0);
    step();
    fi.imem_rvalid = 1'b0;
    chk("stale_rv_valid", 32'(fi.instr_valid), 0);
    chk("stale_rv_instr", 32'(fi.instr), 0);
    fetch(16'h0000, 16'h3333);
    accept(0, 1, 16'h0, 16'hFFFE, 16'd1, 16'hFFFE);
    fetch(16'hFFFE, 16'h4444);
    accept(0, 0, 16'h0, 16'h0, 16'd2, 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
